rvv_backend_alu_p1_arb: RTL and testbench
=========================================

RVV_BACKEND_ALU_P1_ARB -- requirements
Module: rvv_backend_alu_p1_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port alu_uop_valid, input, 2 bits: per-lane valid from the two ALU p0 stages.
REQ-004 SHALL have port alu_uop, input, 2 x PIPE_DATA_t: per-lane uop, including rob_entry, alu_sub_opcode, uop_index, vd_eew and data_viota_per64.
REQ-005 SHALL have port alu_uop_ready, output, 2 bits: per-lane ready.
REQ-006 SHALL have port trap_flush, input, 1 bit: discard all buffered uops.
REQ-007 SHALL have port p1_uop_valid, output, 1 bit: valid to the shared p1 execution stage.
REQ-008 SHALL have port p1_uop, output, PIPE_DATA_t: registered uop to p1.
REQ-009 SHALL have port p1_uop_ready, input, 1 bit: p1/ROB accepts p1_uop this cycle.

Function
REQ-010 SHALL provide one 2-entry FIFO per lane; alu_uop_ready[i] = (count[i] < 2), from registered state only, with no combinational path from any input.
REQ-011 SHALL enqueue lane i when alu_uop_valid[i] && alu_uop_ready[i], with both lanes enqueuing in the same cycle allowed.
REQ-012 SHALL not bypass: a uop enqueued in cycle N is arbitrable at the earliest in N+1, giving p1_uop_valid at the earliest in N+2 (2-cycle minimum latency).
REQ-013 SHALL hold one output register; load_en = !p1_uop_valid || p1_uop_ready.
REQ-014 SHALL, when load_en is set and at least one FIFO is non-empty, grant one head: if only one head is non-empty it is granted; if both are non-empty, lane rr_ptr is granted.
REQ-015 SHALL, on every grant, pop the granted FIFO, load p1_uop, set p1_uop_valid=1, and set rr_ptr to the non-granted lane.
REQ-016 SHALL, when load_en is set and both FIFOs are empty, clear p1_uop_valid; p1_uop keeps its last value.
REQ-017 SHALL hold p1_uop stable and p1_uop_valid high while p1_uop_valid && !p1_uop_ready.
REQ-018 SHALL allow back-to-back issue: with p1_uop_ready held at 1, one uop per cycle is sustained.
REQ-019 SHALL, in a single cycle on a full FIFO, pop the entry while alu_uop_ready stays 0; the enqueue stalls until the next cycle.
REQ-020 SHALL preserve per-lane order; no ordering is guaranteed between lanes (ROB reorders by rob_entry).
REQ-021 SHALL, on trap_flush, at the next edge clear both FIFO counts and p1_uop_valid, ignore same-cycle enqueues and grants, and keep rr_ptr unchanged.
REQ-022 SHALL not modify the uop; the module arbitrates only (multi-uop OP_VIOTA groups are handled by uop_index downstream).

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set FIFO counts and pointers=0, p1_uop_valid=0, p1_uop='0 and rr_ptr=0.
REQ-024 SHALL give rst priority over trap_flush, enqueue and grant; reset mid-transfer drops all in-flight uops.
REQ-025 SHALL drive alu_uop_ready=2'b11 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with macro ALU_P1_ARB_PERF_EN defined, add output perf_stall_cnt (2 x 32 bits): lane i increments when head i is non-empty and not granted, saturates at 32'hFFFF_FFFF, and clears on rst only, not on trap_flush.
REQ-027 SHALL, without ALU_P1_ARB_PERF_EN, omit perf_stall_cnt and its counters; all other behaviour is identical.

Verification
REQ-028 Single lane: lane0 sends uop with rob_entry=3 at cycle 0, p1_uop_ready=1 -> p1_uop_valid=1 with rob_entry=3 at cycle 2 only.
REQ-029 Contention: both lanes send continuously (lane0 rob 0,2,4; lane1 rob 1,3,5), rr_ptr=0 -> p1 order 0,1,2,3,4,5 on consecutive cycles.
REQ-030 Backpressure: p1_uop_ready=0 for 5 cycles with lane1 sending each cycle -> alu_uop_ready[1] falls after 2 accepts, p1_uop is stable, and there is no loss or duplication after release.
REQ-031 Flush: both FIFOs full and p1_uop_valid=1, trap_flush pulsed -> next cycle p1_uop_valid=0, alu_uop_ready=2'b11, and no flushed rob_entry ever appears.
REQ-032 Reset mid-run: rst asserted while lane0 has 2 entries queued -> next cycle all outputs at reset values; with ALU_P1_ARB_PERF_EN, perf_stall_cnt=0.
REQ-033 Perf: ALU_P1_ARB_PERF_EN defined, both lanes full, p1_uop_ready=1 for 4 cycles -> each perf_stall_cnt lane equals 2.

Source files
------------

// File: rtl/rvv_backend_alu_p1_arb.sv
// -----------------------------------------------------------------------------
// rvv_backend_alu_p1_arb
//
// Merges the uop streams of the two ALU p0 lanes into the single shared p1
// execution stage. Each lane has a 2-entry FIFO. The output register is fed
// from the FIFO heads by a round-robin arbiter. Uops pass through unmodified.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid && ready are both 1. A producer may assert valid at any time. Once the
// output side asserts p1_uop_valid, it holds p1_uop stable and keeps
// p1_uop_valid high until p1_uop_ready is seen. Every ready this block drives
// comes from registers only, so it has no combinational path from an input.
//
// Ports
//   clk             : clock; all state updates on its rising edge
//   rst             : synchronous active-high reset; has priority over all else
//   alu_uop_valid   : [1:0] per-lane valid from the ALU p0 stages
//   alu_uop         : [2*DATA_W-1:0] per-lane PIPE_DATA_t; lane i in
//                     bits [DATA_W*i +: DATA_W]
//   alu_uop_ready   : [1:0] per-lane ready (lane FIFO not full)
//   trap_flush      : discards every buffered uop at the next edge
//   p1_uop_valid    : output register holds a uop for p1
//   p1_uop          : [DATA_W-1:0] registered uop for p1
//   p1_uop_ready    : p1/ROB accepts p1_uop this cycle
//   perf_stall_cnt  : [63:0] per-lane stall counters, lane i in [32*i +: 32]
//                     (present only when ALU_P1_ARB_PERF_EN is defined)
//
// Configuration macro: ALU_P1_ARB_PERF_EN adds the perf_stall_cnt counters.
// -----------------------------------------------------------------------------
module rvv_backend_alu_p1_arb #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            alu_uop_valid,
  input  logic [2*DATA_W-1:0]   alu_uop,
  output logic [1:0]            alu_uop_ready,
  input  logic                  trap_flush,
  output logic                  p1_uop_valid,
  output logic [DATA_W-1:0]     p1_uop,
  input  logic                  p1_uop_ready
`ifdef ALU_P1_ARB_PERF_EN
  ,
  output logic [63:0]           perf_stall_cnt
`endif
);

  // Per-lane FIFO state
  logic [DATA_W-1:0] mem [2][2];
  logic [1:0]        cnt [2];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic              rr_ptr;

  logic [1:0]        enq;
  logic [1:0]        not_empty;
  logic [1:0]        grant;
  logic              load_en;
  logic              gnt_lane;
  logic [DATA_W-1:0] gnt_data;

  // Ready depends only on the registered counts. A full FIFO that is popped
  // this cycle still reports not-ready. The producer retries next cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      alu_uop_ready[i] = (cnt[i] != 2'd2);
      not_empty[i]     = (cnt[i] != 2'd0);
    end
  end

  assign enq     = alu_uop_valid & alu_uop_ready;
  assign load_en = !p1_uop_valid || p1_uop_ready;

  // Arbitration happens only from FIFO heads, so a new uop is never bypassed
  // straight into the output register.
  always_comb begin
    grant = 2'b00;
    if (load_en) begin
      if (not_empty == 2'b11) begin
        grant = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        grant = not_empty;
      end
    end
  end

  assign gnt_lane = grant[1];
  assign gnt_data = mem[gnt_lane][rd_ptr[gnt_lane]];

  // FIFO storage needs no reset. The counts decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !trap_flush) begin
      for (int i = 0; i < 2; i++) begin
        if (enq[i]) begin
          mem[i][wr_ptr[i]] <= alu_uop[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  // Control state. trap_flush empties both FIFOs and the output register but
  // leaves rr_ptr alone, so fairness carries across a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= 2'd0;
      end
      wr_ptr       <= 2'b00;
      rd_ptr       <= 2'b00;
      rr_ptr       <= 1'b0;
      p1_uop_valid <= 1'b0;
      p1_uop       <= '0;
    end else if (trap_flush) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= 2'd0;
      end
      wr_ptr       <= 2'b00;
      rd_ptr       <= 2'b00;
      p1_uop_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt[i] + {1'b0, enq[i]} - {1'b0, grant[i]};
        if (enq[i]) begin
          wr_ptr[i] <= ~wr_ptr[i];
        end
        if (grant[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
        end
      end
      if (load_en) begin
        if (grant != 2'b00) begin
          p1_uop       <= gnt_data;
          p1_uop_valid <= 1'b1;
          rr_ptr       <= ~gnt_lane;
        end else begin
          // Nothing to issue: drop valid and keep the stale payload.
          p1_uop_valid <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_P1_ARB_PERF_EN
  // A lane stalls in any cycle where its head is occupied but not granted.
  // This includes cycles where p1 back-pressures the output register. The
  // counters survive trap_flush and clear only on reset.
  logic [31:0] stall_cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        stall_cnt[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (not_empty[i] && !grant[i] && (stall_cnt[i] != 32'hFFFF_FFFF)) begin
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign perf_stall_cnt = {stall_cnt[1], stall_cnt[0]};
`endif

endmodule

// File: tb/tb_rvv_backend_alu_p1_arb.sv
// -----------------------------------------------------------------------------
// tb_rvv_backend_alu_p1_arb
//
// Bench for rvv_backend_alu_p1_arb with DATA_W = 32. Payload layout used
// here: bit 31 = source lane, bits [30:8] = unique sequence tag,
// bits [7:0] = rob_entry. Accepted lane uops go into per-lane expected
// queues. Each uop leaving p1 is checked against the head of its lane's queue,
// which checks per-lane order with no loss and no duplication.
// -----------------------------------------------------------------------------
module tb_rvv_backend_alu_p1_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  alu_uop_valid = 2'b00;
  logic [63:0] alu_uop = '0;
  logic [1:0]  alu_uop_ready;
  logic        trap_flush = 1'b0;
  logic        p1_uop_valid;
  logic [31:0] p1_uop;
  logic        p1_uop_ready = 1'b0;
`ifdef ALU_P1_ARB_PERF_EN
  logic [63:0] perf_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  rvv_backend_alu_p1_arb #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_uop_valid (alu_uop_valid),
    .alu_uop       (alu_uop),
    .alu_uop_ready (alu_uop_ready),
    .trap_flush    (trap_flush),
    .p1_uop_valid  (p1_uop_valid),
    .p1_uop        (p1_uop),
    .p1_uop_ready  (p1_uop_ready)
`ifdef ALU_P1_ARB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge. The values seen here are the ones the
  // next rising edge will act on.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst === 1'b0 && trap_flush === 1'b0) begin
      if (alu_uop_valid[0] && alu_uop_ready[0]) exp_q0.push_back(alu_uop[31:0]);
      if (alu_uop_valid[1] && alu_uop_ready[1]) exp_q1.push_back(alu_uop[63:32]);
      if (p1_uop_valid === 1'b1 && p1_uop_ready) begin
        n_tests++;
        if (p1_uop[31] == 1'b0) begin
          if (exp_q0.size() == 0) begin
            n_fail++;
            $display("FAIL sb_lane0: got %h, expected no uop", p1_uop);
          end else begin
            e = exp_q0.pop_front();
            if (p1_uop !== e) begin
              n_fail++;
              $display("FAIL sb_lane0: got %h, expected %h", p1_uop, e);
            end
          end
        end else begin
          if (exp_q1.size() == 0) begin
            n_fail++;
            $display("FAIL sb_lane1: got %h, expected no uop", p1_uop);
          end else begin
            e = exp_q1.pop_front();
            if (p1_uop !== e) begin
              n_fail++;
              $display("FAIL sb_lane1: got %h, expected %h", p1_uop, e);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic lane, input logic [7:0] rob);
    seq++;
    return {lane, seq[22:0], rob};
  endfunction

  // Presents one cycle of lane stimulus. acc reports which lanes transferred.
  task automatic drive(input logic [1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1, output logic [1:0] acc);
    alu_uop_valid = v;
    alu_uop       = {d1, d0};
    acc           = v & alu_uop_ready;
    tick();
  endtask

  task automatic idle_lanes();
    alu_uop_valid = 2'b00;
  endtask

  task automatic do_reset();
    idle_lanes();
    trap_flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_lanes();
    p1_uop_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (p1_uop_valid !== 1'b0 || p1_uop !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b uop=%h, expected valid=0 uop=0", p1_uop_valid, p1_uop);
    end
    rst = 1'b0;
    n_tests++;
    if (alu_uop_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, expected 11", alu_uop_ready);
    end
    tick();
    n_tests++;
    if (alu_uop_ready !== 2'b11 || p1_uop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b valid=%b, expected ready=11 valid=0", alu_uop_ready, p1_uop_valid);
    end
  endtask

  task automatic test_single_lane();
    logic [1:0] acc;
    logic [31:0] d;
    do_reset();
    p1_uop_ready = 1'b1;
    d = mk(1'b0, 8'd3);
    drive(2'b01, d, 32'h0, acc);   // cycle 0 -> enqueued at this edge
    idle_lanes();
    n_tests++;
    if (p1_uop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c1: got valid=%b, expected 0", p1_uop_valid);
    end
    tick();
    n_tests++;
    if (p1_uop_valid !== 1'b1 || p1_uop[7:0] !== 8'd3) begin
      n_fail++;
      $display("FAIL single_c2: got valid=%b rob=%0d, expected valid=1 rob=3", p1_uop_valid, p1_uop[7:0]);
    end
    tick();
    n_tests++;
    if (p1_uop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c3: got valid=%b, expected 0", p1_uop_valid);
    end
  endtask

  task automatic test_contention();
    logic [31:0] l0 [3];
    logic [31:0] l1 [3];
    logic [7:0]  obs_rob [12];
    int          obs_cyc [12];
    int          n_obs;
    int          i0;
    int          i1;
    logic [1:0]  acc;
    do_reset();
    p1_uop_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      l0[k] = mk(1'b0, 8'(2 * k));
      l1[k] = mk(1'b1, 8'(2 * k + 1));
    end
    n_obs = 0;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 12; c++) begin
      drive({i1 < 3, i0 < 3}, l0[i0 < 3 ? i0 : 2], l1[i1 < 3 ? i1 : 2], acc);
      if (acc[0]) i0++;
      if (acc[1]) i1++;
      if (p1_uop_valid === 1'b1 && n_obs < 12) begin
        obs_rob[n_obs] = p1_uop[7:0];
        obs_cyc[n_obs] = c;
        n_obs++;
      end
    end
    idle_lanes();
    n_tests++;
    if (n_obs != 6) begin
      n_fail++;
      $display("FAIL contention_count: got %0d issues, expected 6", n_obs);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (obs_rob[k] !== 8'(k) || obs_cyc[k] != obs_cyc[0] + k) begin
          n_fail++;
          $display("FAIL contention_order[%0d]: got rob=%0d cyc=%0d, expected rob=%0d cyc=%0d",
                   k, obs_rob[k], obs_cyc[k], k, obs_cyc[0] + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  acc;
    logic [31:0] hold;
    logic [31:0] bp [5];
    int          accepts;
    do_reset();
    p1_uop_ready = 1'b0;
    hold = mk(1'b0, 8'h20);
    for (int k = 0; k < 5; k++) bp[k] = mk(1'b1, 8'(8'h30 + k));
    drive(2'b01, hold, 32'h0, acc);
    idle_lanes();
    tick();
    n_tests++;
    if (p1_uop_valid !== 1'b1 || p1_uop !== hold) begin
      n_fail++;
      $display("FAIL bp_load: got valid=%b uop=%h, expected valid=1 uop=%h", p1_uop_valid, p1_uop, hold);
    end
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      drive(2'b10, 32'h0, bp[accepts], acc);
      if (acc[1]) accepts++;
      n_tests++;
      if (p1_uop_valid !== 1'b1 || p1_uop !== hold) begin
        n_fail++;
        $display("FAIL bp_stable: got valid=%b uop=%h, expected valid=1 uop=%h", p1_uop_valid, p1_uop, hold);
      end
    end
    idle_lanes();
    n_tests++;
    if (accepts != 2 || alu_uop_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready: got accepts=%0d ready1=%b, expected accepts=2 ready1=0", accepts, alu_uop_ready[1]);
    end
    p1_uop_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0 || p1_uop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got q0=%0d q1=%0d valid=%b, expected 0 0 0", exp_q0.size(), exp_q1.size(), p1_uop_valid);
    end
  endtask

  task automatic test_flush();
    logic [1:0]  acc;
    logic [31:0] c0;
    logic [31:0] c1;
    int          n;
    int          bad;
    do_reset();
    p1_uop_ready = 1'b0;
    drive(2'b01, mk(1'b0, 8'h40), 32'h0, acc);
    idle_lanes();
    tick();
    n = 1;
    c0 = mk(1'b0, 8'h41);
    c1 = mk(1'b1, 8'h42);
    for (int c = 0; c < 10 && alu_uop_ready != 2'b00; c++) begin
      drive(2'b11, c0, c1, acc);
      if (acc[0]) begin n++; c0 = mk(1'b0, 8'(8'h42 + n)); end
      if (acc[1]) begin n++; c1 = mk(1'b1, 8'(8'h42 + n)); end
    end
    idle_lanes();
    n_tests++;
    if (alu_uop_ready !== 2'b00 || p1_uop_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_fill: got ready=%b valid=%b, expected ready=00 valid=1", alu_uop_ready, p1_uop_valid);
    end
    trap_flush = 1'b1;
    alu_uop_valid = 2'b11;   // same-cycle enqueue must be ignored
    tick();
    trap_flush = 1'b0;
    idle_lanes();
    exp_q0.delete();
    exp_q1.delete();
    n_tests++;
    if (p1_uop_valid !== 1'b0 || alu_uop_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_clear: got valid=%b ready=%b, expected valid=0 ready=11", p1_uop_valid, alu_uop_ready);
    end
    p1_uop_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 2) drive(2'b11, mk(1'b0, 8'(8'h50 + 2 * c)), mk(1'b1, 8'(8'h51 + 2 * c)), acc);
      else begin idle_lanes(); tick(); end
      if (p1_uop_valid === 1'b1 && p1_uop[7:4] == 4'h4) bad++;
    end
    n_tests++;
    if (bad != 0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL flush_leak: got flushed_seen=%0d q0=%0d q1=%0d, expected 0 0 0", bad, exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] acc;
    do_reset();
    p1_uop_ready = 1'b0;
    drive(2'b10, 32'h0, mk(1'b1, 8'h60), acc);
    idle_lanes();
    tick();
    drive(2'b01, mk(1'b0, 8'h61), 32'h0, acc);
    drive(2'b01, mk(1'b0, 8'h62), 32'h0, acc);
    idle_lanes();
    n_tests++;
    if (alu_uop_ready[0] !== 1'b0 || p1_uop_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: got ready0=%b valid=%b, expected 0 1", alu_uop_ready[0], p1_uop_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    n_tests++;
    if (p1_uop_valid !== 1'b0 || p1_uop !== 32'h0 || alu_uop_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_out: got valid=%b uop=%h ready=%b, expected 0 0 11", p1_uop_valid, p1_uop, alu_uop_ready);
    end
`ifdef ALU_P1_ARB_PERF_EN
    n_tests++;
    if (perf_stall_cnt !== 64'h0) begin
      n_fail++;
      $display("FAIL rstmid_perf: got %h, expected 0", perf_stall_cnt);
    end
`endif
    p1_uop_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (p1_uop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_empty: got valid=%b, expected 0", p1_uop_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] acc;
    int run;
    int max_run;
    int total;
    do_reset();
    p1_uop_ready = 1'b1;
    run = 0;
    max_run = 0;
    total = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(2'b01, mk(1'b0, 8'(8'h70 + c)), 32'h0, acc);
      else begin idle_lanes(); tick(); end
      if (p1_uop_valid === 1'b1) begin
        total++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    n_tests++;
    if (max_run != 8 || total != 8) begin
      n_fail++;
      $display("FAIL b2b_rate: got run=%0d total=%0d, expected 8 8", max_run, total);
    end
  endtask

  task automatic test_random();
    logic [1:0] acc;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      p1_uop_ready = ($urandom_range(0, 3) != 0);
      drive(2'($urandom_range(0, 3)), mk(1'b0, 8'($urandom_range(0, 255))),
            mk(1'b1, 8'($urandom_range(0, 255))), acc);
    end
    idle_lanes();
    p1_uop_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got q0=%0d q1=%0d, expected 0 0", exp_q0.size(), exp_q1.size());
    end
  endtask

`ifdef ALU_P1_ARB_PERF_EN
  task automatic test_perf();
    logic [1:0]  acc;
    logic [31:0] s0;
    logic [31:0] s1;
    do_reset();
    p1_uop_ready = 1'b0;
    drive(2'b01, mk(1'b0, 8'h80), 32'h0, acc);
    idle_lanes();
    tick();
    for (int c = 0; c < 10 && alu_uop_ready != 2'b00; c++) begin
      drive(2'b11, mk(1'b0, 8'h81), mk(1'b1, 8'h82), acc);
    end
    s0 = perf_stall_cnt[31:0];
    s1 = perf_stall_cnt[63:32];
    p1_uop_ready = 1'b1;
    for (int c = 0; c < 4; c++) drive(2'b11, mk(1'b0, 8'h83), mk(1'b1, 8'h84), acc);
    idle_lanes();
    n_tests++;
    if (perf_stall_cnt[31:0] - s0 != 32'd2 || perf_stall_cnt[63:32] - s1 != 32'd2) begin
      n_fail++;
      $display("FAIL perf_delta: got lane0=%0d lane1=%0d, expected 2 2",
               perf_stall_cnt[31:0] - s0, perf_stall_cnt[63:32] - s1);
    end
    for (int c = 0; c < 10; c++) tick();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_lane();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef ALU_P1_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
